// File: rtl/alu_issue_16bit_if.sv
// Issue-side, ALU-side, writeback and debug signals of alu_issue_16bit.
// slave is the issue unit; master is whoever offers instructions and hosts the ALU.
interface alu_issue_16bit_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [2:0]        in_rd;
  logic [2:0]        in_rs1;
  logic [2:0]        in_rs2;
  logic              in_imm_en;
  logic [DATA_W-1:0] in_imm;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [2:0]        alu_op;
  logic [DATA_W-1:0] alu_out;
  logic              alu_zerof;
  logic              wb_valid;
  logic [2:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              zero_flag;
  logic [2:0]        dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm_en, in_imm,
    input  in_ready,
    input  alu_a, alu_b, alu_op,
    output alu_out, alu_zerof,
    input  wb_valid, wb_rd, wb_data, zero_flag,
    output dbg_addr,
    input  dbg_data
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm_en, in_imm,
    output in_ready,
    output alu_a, alu_b, alu_op,
    input  alu_out, alu_zerof,
    output wb_valid, wb_rd, wb_data, zero_flag,
    input  dbg_addr,
    output dbg_data
  );
endinterface

// File: rtl/alu_issue_16bit.sv
// Two-stage issue/execute front end for an external combinational ALU with a small register file.
// Optional macro ALU_ISSUE_FORWARD_EN: bypass alu_out to dependent issues instead of stalling one cycle.
module alu_issue_16bit #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
) (
  input logic              clk,
  input logic              reset,
  alu_issue_16bit_if.slave bus
);
  localparam int RIDX_W = 3;

  logic [DATA_W-1:0] rf_q [NREGS];
  logic [DATA_W-1:0] rf_d [NREGS];
  logic              ex_valid_q, ex_valid_d;
  logic [2:0]        ex_op_q, ex_op_d;
  logic [RIDX_W-1:0] ex_rd_q, ex_rd_d;
  logic [DATA_W-1:0] ex_a_q, ex_a_d;
  logic [DATA_W-1:0] ex_b_q, ex_b_d;
  logic              wb_valid_q, wb_valid_d;
  logic [RIDX_W-1:0] wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              zero_flag_q, zero_flag_d;
  logic              wr_en;
  logic              hazard;
  logic              accept;

`ifdef ALU_ISSUE_FORWARD_EN
  assign hazard = 1'b0;
`else
  assign hazard = ex_valid_q && (ex_rd_q != '0) &&
                  ((ex_rd_q == bus.in_rs1) || (!bus.in_imm_en && (ex_rd_q == bus.in_rs2)));
`endif

  assign bus.in_ready = !reset && !hazard;

  always_comb begin
    // rf_d is the post-writeback file, so issue reads see the completing result
    rf_d  = rf_q;
    wr_en = ex_valid_q && (ex_rd_q != '0);
    if (wr_en) rf_d[ex_rd_q] = bus.alu_out;

    accept     = bus.in_valid && bus.in_ready;
    ex_valid_d = accept;
    ex_op_d    = ex_op_q;
    ex_rd_d    = ex_rd_q;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    if (accept) begin
      ex_op_d = bus.in_op;
      ex_rd_d = bus.in_rd;
      ex_a_d  = rf_d[bus.in_rs1];
      ex_b_d  = bus.in_imm_en ? bus.in_imm : rf_d[bus.in_rs2];
    end

    wb_valid_d  = ex_valid_q;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    zero_flag_d = zero_flag_q;
    if (ex_valid_q) begin
      wb_rd_d     = ex_rd_q;
      wb_data_d   = bus.alu_out;
      zero_flag_d = bus.alu_zerof;
    end
  end

  // issue -> execute -> writeback stage registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
      ex_valid_q  <= 1'b0;
      ex_op_q     <= '0;
      ex_rd_q     <= '0;
      ex_a_q      <= '0;
      ex_b_q      <= '0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      zero_flag_q <= 1'b0;
    end else begin
      rf_q        <= rf_d;
      ex_valid_q  <= ex_valid_d;
      ex_op_q     <= ex_op_d;
      ex_rd_q     <= ex_rd_d;
      ex_a_q      <= ex_a_d;
      ex_b_q      <= ex_b_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      zero_flag_q <= zero_flag_d;
    end
  end

  assign bus.alu_a     = ex_a_q;
  assign bus.alu_b     = ex_b_q;
  assign bus.alu_op    = ex_op_q;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.zero_flag = zero_flag_q;
  assign bus.dbg_data  = rf_q[bus.dbg_addr];
endmodule
